breath_led_array: RTL and testbench

Parametrised multi-channel breathing-LED driver. A single shared PWM counter drives CH independent duty generators. Each channel runs a triangle-wave duty ramp with an evenly staggered start phase. A per-channel mode selects off, on, breath or blink. The block sits between board-level control (mode/pause/sync from switches or a register block) and the LED pins.

---
 rtl/breath_led_array.sv | 126 ++++++++++++
 tb/tb_breath_led_array.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/breath_led_array.sv
// Multi-channel breathing-LED driver: one shared PWM counter, per-channel triangle duty ramps
// with staggered start phases, and per-channel off/on/breath/blink mode selection.
module breath_led_array #(
   parameter int CH          = 4,
   parameter int PWM_MAX     = 100,
   parameter int STEP_DIV    = 4,
   parameter int PHASE_EN    = 1,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic            sys_clk,
   input  logic            sys_rst_n,
   input  logic [2*CH-1:0] mode,
   input  logic            pause,
   input  logic            sync,
   output logic [CH-1:0]   led,
   output logic            step_tick
);

   localparam int CW = $clog2(PWM_MAX + 1);
   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PWM_MAX - 1);
   localparam logic [CW-1:0] DUTY_MAX = CW'(PWM_MAX);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);
   localparam logic [CH-1:0] INV      = (ACTIVE_HIGH != 0) ? '0 : '1;

   // Position of channel i on the unfolded 0..2*PWM_MAX triangle.
   function automatic int phase_v(input int i);
      return (i * 2 * PWM_MAX) / CH;
   endfunction

   logic [CW-1:0] cnt_reg;
   logic [DW-1:0] div_reg;
   logic          wrap;
   logic          div_last;
   logic [CH-1:0] on_vec;

   assign wrap      = (cnt_reg == CNT_LAST);
   assign div_last  = (div_reg == DIV_LAST);
   assign step_tick = wrap & div_last & ~pause & ~sync;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_reg <= '0;
         div_reg <= '0;
      end else if (sync) begin
         cnt_reg <= '0;
         div_reg <= '0;
      end else begin
         cnt_reg <= wrap ? '0 : cnt_reg + ONE;
         if (wrap && !pause)
            div_reg <= div_last ? '0 : div_reg + DIV_ONE;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         localparam int            V         = phase_v(gi);
         localparam logic [CW-1:0] INIT_DUTY = (PHASE_EN == 0) ? '0 :
                                               (V <= PWM_MAX) ? CW'(V) : CW'(2 * PWM_MAX - V);
         localparam logic          INIT_UP   = (PHASE_EN == 0) || (V <= PWM_MAX);

         logic [CW-1:0] duty_reg, duty_next;
         logic          up_reg, up_next;
         logic          on_bit;

         // Every channel steps on every tick regardless of mode so the phase offsets hold.
         always_comb begin
            duty_next = duty_reg;
            up_next   = up_reg;
            if (step_tick) begin
               if (up_reg) begin
                  if (duty_reg == DUTY_MAX) begin
                     duty_next = DUTY_MAX - ONE;
                     up_next   = 1'b0;
                  end else begin
                     duty_next = duty_reg + ONE;
                  end
               end else begin
                  if (duty_reg == '0) begin
                     duty_next = ONE;
                     up_next   = 1'b1;
                  end else begin
                     duty_next = duty_reg - ONE;
                  end
               end
            end
         end

         always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               duty_reg <= INIT_DUTY;
               up_reg   <= INIT_UP;
            end else if (sync) begin
               duty_reg <= INIT_DUTY;
               up_reg   <= INIT_UP;
            end else begin
               duty_reg <= duty_next;
               up_reg   <= up_next;
            end
         end

         always_comb begin
            on_bit = 1'b0;
            case (mode[2*gi +: 2])
               2'b00:   on_bit = 1'b0;
               2'b01:   on_bit = 1'b1;
               2'b10:   on_bit = (cnt_reg < duty_reg);
               default: on_bit = up_reg;
            endcase
         end

         assign on_vec[gi] = on_bit;
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         led <= INV;
      else
         led <= on_vec ^ INV;
   end

endmodule

// File: tb/tb_breath_led_array.sv
// Scoreboard bench: a cycle model predicts step_tick and led for three configurations
// (phased active-high, phased active-low, unphased long-period) driven from shared inputs.
module tb_breath_led_array;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] mode_a;
   logic [5:0] mode_c;
   logic       pause;
   logic       sync;
   logic [3:0] led_a, led_b;
   logic [2:0] led_c;
   logic       st_a, st_b, st_c;

   int n_total = 0;
   int n_bad   = 0;
   int stc     = 0;

   // Model state: index 0 = CH4/PWM4/DIV2/phased, index 1 = CH3/PWM100/DIV1/unphased.
   int         m_cnt[2];
   int         m_div[2];
   int         m_duty[2][4];
   bit         m_up[2][4];
   bit         exp_st[2];
   logic [3:0] exp_on[2];
   logic [10:0] sb[$];

   always #5 clk = ~clk;

   breath_led_array #(.CH(4), .PWM_MAX(4), .STEP_DIV(2), .PHASE_EN(1), .ACTIVE_HIGH(1)) dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode_a), .pause(pause), .sync(sync),
      .led(led_a), .step_tick(st_a));

   breath_led_array #(.CH(4), .PWM_MAX(4), .STEP_DIV(2), .PHASE_EN(1), .ACTIVE_HIGH(0)) dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode_a), .pause(pause), .sync(sync),
      .led(led_b), .step_tick(st_b));

   breath_led_array #(.CH(3), .PWM_MAX(100), .STEP_DIV(1), .PHASE_EN(0), .ACTIVE_HIGH(1)) dut_c (
      .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode_c), .pause(pause), .sync(sync),
      .led(led_c), .step_tick(st_c));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pm_of(input int k); return (k == 0) ? 4 : 100; endfunction
   function automatic int sd_of(input int k); return (k == 0) ? 2 : 1;   endfunction
   function automatic int ch_of(input int k); return (k == 0) ? 4 : 3;   endfunction
   function automatic bit pe_of(input int k); return (k == 0);           endfunction

   task automatic model_init(input int k);
      int pm, v;
      pm = pm_of(k);
      m_cnt[k] = 0;
      m_div[k] = 0;
      for (int j = 0; j < 4; j++) begin
         v = (j * 2 * pm) / ch_of(k);
         if (!pe_of(k)) begin
            m_duty[k][j] = 0;
            m_up[k][j]   = 1'b1;
         end else if (v <= pm) begin
            m_duty[k][j] = v;
            m_up[k][j]   = 1'b1;
         end else begin
            m_duty[k][j] = 2 * pm - v;
            m_up[k][j]   = 1'b0;
         end
      end
   endtask

   task automatic model_reset();
      model_init(0);
      model_init(1);
   endtask

   // Evaluate outputs from the pre-edge state, then advance the model across the edge.
   task automatic model_clock();
      int  pm, sd;
      bit  wrap, st;
      logic [1:0] md;
      logic [3:0] on;
      for (int k = 0; k < 2; k++) begin
         pm   = pm_of(k);
         sd   = sd_of(k);
         wrap = (m_cnt[k] == pm - 1);
         st   = wrap && (m_div[k] == sd - 1) && !pause && !sync;
         exp_st[k] = st;
         on = 4'b0;
         for (int j = 0; j < ch_of(k); j++) begin
            md = (k == 0) ? mode_a[2*j +: 2] : mode_c[2*j +: 2];
            case (md)
               2'b00:   on[j] = 1'b0;
               2'b01:   on[j] = 1'b1;
               2'b10:   on[j] = (m_cnt[k] < m_duty[k][j]);
               default: on[j] = m_up[k][j];
            endcase
         end
         exp_on[k] = on;
         if (sync) begin
            model_init(k);
         end else begin
            m_cnt[k] = wrap ? 0 : m_cnt[k] + 1;
            if (wrap && !pause) m_div[k] = (m_div[k] + 1) % sd;
            if (st) begin
               for (int j = 0; j < 4; j++) begin
                  if (m_up[k][j]) begin
                     if (m_duty[k][j] == pm) begin
                        m_duty[k][j] = pm - 1;
                        m_up[k][j]   = 1'b0;
                     end else m_duty[k][j]++;
                  end else begin
                     if (m_duty[k][j] == 0) begin
                        m_duty[k][j] = 1;
                        m_up[k][j]   = 1'b1;
                     end else m_duty[k][j]--;
                  end
               end
            end
         end
      end
   endtask

   // Called just after a falling edge with inputs already set; returns at the next falling edge.
   task automatic run(input int n);
      logic [10:0] e;
      repeat (n) begin
         #1;
         model_clock();
         check_val("step_tick_a", st_a, exp_st[0]);
         check_val("step_tick_b", st_b, exp_st[0]);
         check_val("step_tick_c", st_c, exp_st[1]);
         if (st_a) stc++;
         sb.push_back({exp_on[0], ~exp_on[0], exp_on[1][2:0]});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check_val("led_a", led_a, e[10:7]);
         check_val("led_b", led_b, e[6:3]);
         check_val("led_c", led_c, e[2:0]);
         @(negedge clk);
      end
   endtask

   initial begin
      int s0, guard;
      rst_n  = 1'b0;
      mode_a = 8'b10_10_10_10;
      mode_c = 6'b10_10_10;
      pause  = 1'b0;
      sync   = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      #1;
      check_val("rst_led_a", led_a, 4'b0000);
      check_val("rst_led_b", led_b, 4'b1111);
      check_val("rst_led_c", led_c, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // First step lands on clock 8; a full triangle is 8 steps in 64 clocks.
      s0 = stc;
      run(8);
      check_val("first_step_count", stc - s0, 1);
      run(56);
      check_val("steps_in_64", stc - s0, 8);

      // ch3 on, ch2 off, ch1 blink, ch0 breath.
      mode_a = 8'b01_00_11_10;
      run(48);

      run(3);
      s0 = stc;
      pause = 1'b1;
      run(20);
      check_val("pause_no_steps", stc - s0, 0);
      pause = 1'b0;
      run(30);

      // Land sync exactly on a cycle that would otherwise step.
      guard = 0;
      while (!(m_cnt[0] == 3 && m_div[0] == 1) && guard < 100) begin
         run(1);
         guard++;
      end
      if (guard >= 100) check_val("sync_align_timeout", guard, 0);
      sync = 1'b1;
      run(1);
      sync = 1'b0;
      run(20);

      pause = 1'b1;
      run(3);
      sync = 1'b1;
      run(1);
      sync = 1'b0;
      run(5);
      pause = 1'b0;
      run(24);

      // Asynchronous reset mid-ramp drops the outputs without waiting for an edge.
      #3;
      rst_n = 1'b0;
      #1;
      check_val("arst_led_a", led_a, 4'b0000);
      check_val("arst_led_b", led_b, 4'b1111);
      check_val("arst_led_c", led_c, 3'b000);
      sb.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Unphased channels climb together to full duty after 100 steps.
      mode_a = 8'b10_10_10_10;
      run(10000);
      for (int m = 0; m < 100; m++) begin
         run(1);
         check_val("phoff_full_on", led_c, 3'b111);
      end
      run(120);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
